on_chip_fsm_pio_bank: RTL and testbench
=======================================

# on_chip_fsm_pio_bank

Parametrised multi-channel Avalon-MM output register bank, successor to the single-channel per-colour output PIOs in the on_chip_fsm system. One slave drives CHANNELS output words (e.g. red/green/blue thresholds) with per-bit set/clear access and live-value readback. An optional frame-synchronous mode double-buffers writes so all channels update atomically on a rising frame_sync edge, avoiding mid-frame tearing in the camera pipeline.

## Interface
- WIDTH, 32: bits per channel, 1..32.
- CHANNELS, 3: number of output channels, 1..8.
- RESET_VALUE, 0: reset value of every shadow and live register (WIDTH bits).
- ADDR_W, $clog2(CHANNELS+1)+2: derived address width; not overridden.

- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous active-low reset.
- address  in  ADDR_W  word address: upper bits = channel index (index CHANNELS = control block), low 2 bits = register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data; bits above WIDTH ignored.
- readdata  out  32  combinational read data, zero-extended above WIDTH.
- frame_sync  in  1  frame marker, synchronous to clk.
- out_port  out  WIDTH*CHANNELS  live values, channel c at [c*WIDTH +: WIDTH].
- commit_pending  out  1  high while a frame-synchronous commit is armed.

## Operation
- Channel c register map (low 2 bits): 0 SHADOW (R/W), 1 OUTSET (W: shadow |= data), 2 OUTCLEAR (W: shadow &= ~data), 3 LIVE (R: current out_port slice; writes ignored).
- Control block: 0 CTRL (R/W, bit0 sync_mode), 1 COMMIT (W any value: arm commit), 2 STATUS (R, bit0 commit_pending), 3 reserved (reads 0).
- Write = chipselect && !write_n. Reads of write-only or unmapped addresses (channel index > CHANNELS) return 0; writes there ignored.
- sync_mode=0 (immediate): every SHADOW/OUTSET/OUTCLEAR write updates shadow and live of that channel in the same edge; COMMIT writes ignored, pending stays 0.
- sync_mode=1 (framed): writes update shadow only. COMMIT sets pending. On a cycle where pending=1 and frame_sync rising edge (frame_sync && !frame_sync_q), all live <= shadow values present before that edge, pending <= 0.
- Simultaneous COMMIT write and rising edge: pending was 0, so no commit this frame; pending <= 1 and commits on the next edge.
- Simultaneous shadow write and commit edge: live takes the old shadow; new shadow value stays buffered.
- Clearing sync_mode (CTRL write bit0=0) while pending: pending <= 0, live unchanged until the next channel write; no implicit commit.
- Setting sync_mode does not change live.

## Timing
- Reset (async assert): shadow = live = RESET_VALUE for all channels, sync_mode = 0, pending = 0, frame_sync_q = 0; out_port = {CHANNELS{RESET_VALUE}}, commit_pending = 0, readdata follows address (comb).
- Zero wait-state slave; readdata valid combinationally the cycle address is presented; no read side effects.
- Immediate mode: out_port reflects a write on the edge that samples it (1-cycle write-to-output).
- Framed mode: out_port changes exactly on the clk edge where rising frame_sync is sampled with pending=1; all channels change on the same edge.
- frame_sync held high through reset release: frame_sync_q=0 so the first sampled cycle counts as a rising edge.
- Reset mid-frame discards shadow contents and any armed commit.

## Structure
- Package on_chip_fsm_pio_pkg: register offset constants (REG_SHADOW/OUTSET/OUTCLEAR/LIVE, REG_CTRL/COMMIT/STATUS), CTRL bit index.
- Sub-module on_chip_fsm_pio_channel, generated CHANNELS times: holds shadow/live, applies set/clear, takes write-enable, mode and commit inputs; top holds address decode, control block, edge detector, read mux.

## Test plan
- Reset, CHANNELS=3, RESET_VALUE=0x5: out_port=0x000000050000000500000005, all LIVE reads 5, STATUS=0.
- Immediate: write ch1 SHADOW=0xF0, OUTSET 0x0F, OUTCLEAR 0x81 -> ch1 live 0xF0, 0xFF, 0x7E, each one edge after the write.
- Framed: CTRL=1, write ch0=0x11, ch2=0x22, COMMIT -> out_port unchanged, commit_pending=1; frame_sync pulse -> both update on same edge, pending=0.
- COMMIT write coincident with frame_sync rise -> no update that edge; update on next rise.
- Shadow write to ch0=0x33 coincident with commit edge (shadow was 0x11) -> live=0x11, SHADOW read=0x33.
- Reads of address for channel index CHANNELS+1 and COMMIT register return 0; write there leaves all state unchanged; assert reset_n low with pending=1 -> all registers back to RESET_VALUE, pending=0.

Source files
------------

// File: rtl/on_chip_fsm_pio_pkg.sv
// Register map constants shared by the multi-channel PIO bank and its channel slices.
package on_chip_fsm_pio_pkg;

    localparam logic [1:0] REG_SHADOW   = 2'd0;
    localparam logic [1:0] REG_OUTSET   = 2'd1;
    localparam logic [1:0] REG_OUTCLEAR = 2'd2;
    localparam logic [1:0] REG_LIVE     = 2'd3;

    localparam logic [1:0] REG_CTRL     = 2'd0;
    localparam logic [1:0] REG_COMMIT   = 2'd1;
    localparam logic [1:0] REG_STATUS   = 2'd2;

    localparam int CTRL_SYNC_BIT = 0;

endpackage

// File: rtl/on_chip_fsm_pio_channel.sv
// One output channel: a shadow register with set/clear access and the live value driven to the pins.
module on_chip_fsm_pio_channel
    import on_chip_fsm_pio_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [1:0]       wr_reg,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             sync_mode,
    input  logic             commit,
    output logic [WIDTH-1:0] shadow,
    output logic [WIDTH-1:0] live
);

    logic             shadow_wr;
    logic [WIDTH-1:0] shadow_next;

    assign shadow_wr = wr_en && (wr_reg != REG_LIVE);

    always_comb begin
        shadow_next = shadow;
        case (wr_reg)
            REG_SHADOW:   shadow_next = wr_data;
            REG_OUTSET:   shadow_next = shadow | wr_data;
            REG_OUTCLEAR: shadow_next = shadow & ~wr_data;
            default:      shadow_next = shadow;
        endcase
    end

    // A commit copies the shadow as it stood before this edge, so a coincident write stays buffered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow <= RESET_VALUE;
            live   <= RESET_VALUE;
        end else begin
            if (shadow_wr) begin
                shadow <= shadow_next;
            end
            if (shadow_wr && !sync_mode) begin
                live <= shadow_next;
            end else if (commit) begin
                live <= shadow;
            end
        end
    end

endmodule

// File: rtl/on_chip_fsm_pio_bank.sv
// Avalon-MM multi-channel output register bank with optional frame-synchronous atomic commit.
module on_chip_fsm_pio_bank
    import on_chip_fsm_pio_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               CHANNELS    = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               ADDR_W      = $clog2(CHANNELS + 1) + 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [ADDR_W-1:0]         address,
    input  logic                      chipselect,
    input  logic                      write_n,
    input  logic [31:0]               writedata,
    output logic [31:0]               readdata,
    input  logic                      frame_sync,
    output logic [WIDTH*CHANNELS-1:0] out_port,
    output logic                      commit_pending
);

    localparam int CH_W = ADDR_W - 2;

    logic [CH_W-1:0]  ch_idx;
    logic [1:0]       reg_off;
    logic             bus_wr;
    logic             ctrl_sel;
    logic             sync_mode;
    logic             pending;
    logic             frame_sync_q;
    logic             commit_fire;
    logic             ctrl_wr;
    logic             commit_wr;
    logic [WIDTH-1:0] shadow [CHANNELS];
    logic [WIDTH-1:0] live   [CHANNELS];

    assign ch_idx      = address[ADDR_W-1:2];
    assign reg_off     = address[1:0];
    assign bus_wr      = chipselect && !write_n;
    assign ctrl_sel    = (ch_idx == CH_W'(CHANNELS));
    assign ctrl_wr     = bus_wr && ctrl_sel && (reg_off == REG_CTRL);
    assign commit_wr   = bus_wr && ctrl_sel && (reg_off == REG_COMMIT);
    assign commit_fire = pending && frame_sync && !frame_sync_q;

    assign commit_pending = pending;

    genvar c;
    generate
        for (c = 0; c < CHANNELS; c++) begin : g_chan
            on_chip_fsm_pio_channel #(
                .WIDTH       (WIDTH),
                .RESET_VALUE (RESET_VALUE)
            ) u_chan (
                .clk       (clk),
                .reset_n   (reset_n),
                .wr_en     (bus_wr && (ch_idx == CH_W'(c))),
                .wr_reg    (reg_off),
                .wr_data   (writedata[WIDTH-1:0]),
                .sync_mode (sync_mode),
                .commit    (commit_fire),
                .shadow    (shadow[c]),
                .live      (live[c])
            );
            assign out_port[c*WIDTH +: WIDTH] = live[c];
        end
    endgenerate

    // Leaving framed mode drops an armed commit; a COMMIT write re-arms even on the edge that fires.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_mode    <= 1'b0;
            pending      <= 1'b0;
            frame_sync_q <= 1'b0;
        end else begin
            frame_sync_q <= frame_sync;
            if (ctrl_wr) begin
                sync_mode <= writedata[CTRL_SYNC_BIT];
            end
            if (ctrl_wr && !writedata[CTRL_SYNC_BIT]) begin
                pending <= 1'b0;
            end else if (commit_wr && sync_mode) begin
                pending <= 1'b1;
            end else if (commit_fire) begin
                pending <= 1'b0;
            end
        end
    end

    always_comb begin
        readdata = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_idx == CH_W'(i)) begin
                case (reg_off)
                    REG_SHADOW: readdata[WIDTH-1:0] = shadow[i];
                    REG_LIVE:   readdata[WIDTH-1:0] = live[i];
                    default:    readdata = '0;
                endcase
            end
        end
        if (ctrl_sel) begin
            case (reg_off)
                REG_CTRL:   readdata[CTRL_SYNC_BIT] = sync_mode;
                REG_STATUS: readdata[0] = pending;
                default:    readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_on_chip_fsm_pio_bank.sv
// Directed bench for on_chip_fsm_pio_bank: a register-map model checked every cycle plus literal pins.
module tb_on_chip_fsm_pio_bank;

    localparam int NCH = 3;

    logic         clk;
    logic         reset_n;
    logic [3:0]   address;
    logic         chipselect;
    logic         write_n;
    logic [31:0]  writedata;
    logic [31:0]  readdata;
    logic         frame_sync;
    logic [95:0]  out_port;
    logic         commit_pending;

    int checks = 0;
    int errors = 0;

    int unsigned m_shadow [NCH];
    int unsigned m_live   [NCH];
    bit          m_sync;
    bit          m_pending;
    bit          m_fs_q;

    on_chip_fsm_pio_bank #(
        .WIDTH       (32),
        .CHANNELS    (NCH),
        .RESET_VALUE (32'h5)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .address        (address),
        .chipselect     (chipselect),
        .write_n        (write_n),
        .writedata      (writedata),
        .readdata       (readdata),
        .frame_sync     (frame_sync),
        .out_port       (out_port),
        .commit_pending (commit_pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int unsigned apply_op(int off, int unsigned s, int unsigned d);
        case (off)
            0:       return d;
            1:       return s | d;
            2:       return s & ~d;
            default: return s;
        endcase
    endfunction

    function automatic logic [31:0] exp_read(logic [3:0] a);
        int idx = int'(a[3:2]);
        int off = int'(a[1:0]);
        if (idx < NCH) begin
            if (off == 0) return m_shadow[idx];
            if (off == 3) return m_live[idx];
            return 32'h0;
        end
        if (off == 0) return {31'h0, m_sync};
        if (off == 2) return {31'h0, m_pending};
        return 32'h0;
    endfunction

    // Register-map model: the effect of each sampled bus cycle and frame marker on shadow/live/pending.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                m_shadow[i] <= 32'h5;
                m_live[i]   <= 32'h5;
            end
            m_sync    <= 1'b0;
            m_pending <= 1'b0;
            m_fs_q    <= 1'b0;
        end else begin
            automatic bit wr   = chipselect && !write_n;
            automatic int idx  = int'(address[3:2]);
            automatic int off  = int'(address[1:0]);
            automatic bit fire = m_pending && frame_sync && !m_fs_q;
            m_fs_q <= frame_sync;
            if (fire) begin
                for (int i = 0; i < NCH; i++) m_live[i] <= m_shadow[i];
            end
            if (wr && idx < NCH && off != 3) begin
                m_shadow[idx] <= apply_op(off, m_shadow[idx], writedata);
                if (!m_sync) m_live[idx] <= apply_op(off, m_shadow[idx], writedata);
            end
            if (wr && idx == NCH && off == 0) m_sync <= writedata[0];
            if (wr && idx == NCH && off == 0 && !writedata[0]) m_pending <= 1'b0;
            else if (wr && idx == NCH && off == 1 && m_sync) m_pending <= 1'b1;
            else if (fire) m_pending <= 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("model out_port", 128'(out_port), 128'({m_live[2], m_live[1], m_live[0]}));
        checkOutput("model commit_pending", 128'(commit_pending), 128'(m_pending));
        checkOutput("model readdata", 128'(readdata), 128'(exp_read(address)));
    end

    task automatic applyStimulus(input bit cs, input bit wn, input logic [3:0] a,
                                 input logic [31:0] d, input bit fs);
        @(posedge clk);
        #1;
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = d;
        frame_sync = fs;
    endtask

    task automatic wrReg(input logic [3:0] a, input logic [31:0] d, input bit fs);
        applyStimulus(1'b1, 1'b0, a, d, fs);
    endtask

    task automatic idle(input bit fs);
        applyStimulus(1'b0, 1'b1, 4'd0, 32'h0, fs);
    endtask

    task automatic readCheck(input string name, input logic [3:0] a, input logic [31:0] expected);
        applyStimulus(1'b0, 1'b1, a, 32'h0, 1'b0);
        #1;
        checkOutput(name, 128'(readdata), 128'(expected));
    endtask

    initial begin
        reset_n    = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 4'd0;
        writedata  = 32'h0;
        frame_sync = 1'b0;
        #2 reset_n = 1'b0;
        #3;
        checkOutput("reset out_port", 128'(out_port), 128'h00000005_00000005_00000005);
        checkOutput("reset pending", 128'(commit_pending), 128'h0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        readCheck("reset live ch0", 4'd3, 32'h5);
        readCheck("reset live ch1", 4'd7, 32'h5);
        readCheck("reset live ch2", 4'd11, 32'h5);
        readCheck("reset status", 4'd14, 32'h0);

        wrReg(4'd4, 32'hF0, 1'b0);
        idle(1'b0);
        checkOutput("imm shadow ch1", 128'(out_port[63:32]), 128'hF0);
        wrReg(4'd5, 32'h0F, 1'b0);
        idle(1'b0);
        checkOutput("imm outset ch1", 128'(out_port[63:32]), 128'hFF);
        wrReg(4'd6, 32'h81, 1'b0);
        idle(1'b0);
        checkOutput("imm outclear ch1", 128'(out_port[63:32]), 128'h7E);

        wrReg(4'd12, 32'h1, 1'b0);
        wrReg(4'd0, 32'h11, 1'b0);
        wrReg(4'd8, 32'h22, 1'b0);
        wrReg(4'd13, 32'hABCD, 1'b0);
        idle(1'b0);
        checkOutput("framed held out_port", 128'(out_port), 128'h00000005_0000007E_00000005);
        checkOutput("framed armed", 128'(commit_pending), 128'h1);
        idle(1'b1);
        idle(1'b0);
        checkOutput("framed commit out_port", 128'(out_port), 128'h00000022_0000007E_00000011);
        checkOutput("framed commit pending", 128'(commit_pending), 128'h0);

        wrReg(4'd0, 32'h44, 1'b0);
        wrReg(4'd13, 32'h0, 1'b1);
        idle(1'b1);
        checkOutput("coincident commit armed", 128'(commit_pending), 128'h1);
        checkOutput("coincident commit no update", 128'(out_port[31:0]), 128'h11);
        idle(1'b0);
        checkOutput("held sync no rise", 128'(out_port[31:0]), 128'h11);
        idle(1'b1);
        idle(1'b0);
        checkOutput("next rise commits", 128'(out_port[31:0]), 128'h44);
        checkOutput("next rise clears pending", 128'(commit_pending), 128'h0);

        wrReg(4'd0, 32'h11, 1'b0);
        wrReg(4'd13, 32'h0, 1'b0);
        wrReg(4'd0, 32'h33, 1'b1);
        idle(1'b0);
        checkOutput("write at commit edge live", 128'(out_port[31:0]), 128'h11);
        readCheck("write at commit edge shadow", 4'd0, 32'h33);

        readCheck("commit reg reads 0", 4'd13, 32'h0);
        readCheck("reserved reads 0", 4'd15, 32'h0);
        wrReg(4'd3, 32'hDEAD, 1'b0);
        wrReg(4'd15, 32'hFFFF, 1'b0);
        wrReg(4'd14, 32'h1, 1'b0);
        idle(1'b0);
        checkOutput("ignored writes out_port", 128'(out_port), 128'h00000022_0000007E_00000011);
        checkOutput("ignored writes pending", 128'(commit_pending), 128'h0);
        readCheck("ignored writes shadow ch0", 4'd0, 32'h33);
        readCheck("ctrl readback", 4'd12, 32'h1);

        wrReg(4'd8, 32'h99, 1'b0);
        wrReg(4'd13, 32'h0, 1'b0);
        idle(1'b0);
        checkOutput("arm before clear", 128'(commit_pending), 128'h1);
        wrReg(4'd12, 32'h0, 1'b0);
        idle(1'b0);
        checkOutput("clear sync drops pending", 128'(commit_pending), 128'h0);
        checkOutput("clear sync keeps live", 128'(out_port), 128'h00000022_0000007E_00000011);
        wrReg(4'd5, 32'h100, 1'b0);
        idle(1'b0);
        checkOutput("imm after clear", 128'(out_port), 128'h00000022_0000017E_00000011);
        readCheck("ch2 shadow buffered", 4'd8, 32'h99);

        wrReg(4'd12, 32'h1, 1'b0);
        wrReg(4'd13, 32'h0, 1'b0);
        idle(1'b0);
        checkOutput("pending before reset", 128'(commit_pending), 128'h1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("mid reset out_port", 128'(out_port), 128'h00000005_00000005_00000005);
        checkOutput("mid reset pending", 128'(commit_pending), 128'h0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        readCheck("post reset ctrl", 4'd12, 32'h0);
        readCheck("post reset shadow ch2", 4'd8, 32'h5);
        idle(1'b0);
        idle(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
